// File: rtl/branch_predictor_ras_bht_pkg.sv
// Shared types, MIPS encoding constants and decode helpers for the fetch-stage
// branch predictor (BHT direction table + return-address stack).
package bp_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_INIT = 2'b01;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;
    localparam logic [4:0] REG_RA     = 5'd31;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_JUMP,
        CLS_COND,
        CLS_INDIRECT
    } inst_class_t;

    function automatic inst_class_t classify(logic [31:0] inst);
        inst_class_t cls;
        cls = CLS_NONE;
        case (inst[31:26])
            OP_J, OP_JAL:                    cls = CLS_JUMP;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_COND;
            OP_REGIMM: begin
                if (inst[20:16] == RT_BLTZ   || inst[20:16] == RT_BGEZ ||
                    inst[20:16] == RT_BLTZAL || inst[20:16] == RT_BGEZAL)
                    cls = CLS_COND;
            end
            OP_SPECIAL: begin
                if (inst[5:0] == FN_JR || inst[5:0] == FN_JALR)
                    cls = CLS_INDIRECT;
            end
            default: cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    // Saturating 2-bit counter step.
    function automatic bht_ctr_t ctr_next(bht_ctr_t c, logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predictor_ras_bht_if.sv
// Fetch/predict/resolve signal bundle between the fetch stage and the predictor.
interface branch_predictor_ras_bht_if;

    logic        stall;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_inst;
    logic        pred_is_branch;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_is_call;
    logic        pred_is_return;
    logic        upd_valid;
    logic        upd_is_cond;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        ras_flush;
    logic        ras_empty;
    logic        ras_full;

    modport master (
        output stall, f_valid, f_pc, f_inst,
        output upd_valid, upd_is_cond, upd_pc, upd_taken, ras_flush,
        input  pred_is_branch, pred_taken, pred_target, pred_is_call, pred_is_return,
        input  ras_empty, ras_full
    );

    modport slave (
        input  stall, f_valid, f_pc, f_inst,
        input  upd_valid, upd_is_cond, upd_pc, upd_taken, ras_flush,
        output pred_is_branch, pred_taken, pred_target, pred_is_call, pred_is_return,
        output ras_empty, ras_full
    );

endinterface

// File: rtl/branch_predictor_ras_bht_ras.sv
// Circular return-address stack. Overflow overwrites the oldest entry; a
// simultaneous pop+push replaces the top; flush empties it.
module bp_ras #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty,
    output logic        full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, wr_ptr_next, top_ptr, mem_addr;
    logic [PW:0]   count, count_next;
    logic          mem_we, do_pop;

    assign top_ptr = wr_ptr - 1'b1;
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);

    // Next pointer/count and memory write selection.
    always_comb begin
        wr_ptr_next = wr_ptr;
        count_next  = count;
        mem_we      = 1'b0;
        mem_addr    = wr_ptr;
        do_pop      = pop && (count != '0);
        if (flush) begin
            count_next = '0;
        end else if (do_pop && push) begin
            mem_we   = 1'b1;
            mem_addr = top_ptr;
        end else if (do_pop) begin
            wr_ptr_next = top_ptr;
            count_next  = count - 1'b1;
        end else if (push) begin
            mem_we      = 1'b1;
            wr_ptr_next = wr_ptr + 1'b1;
            if (count != FULL_COUNT)
                count_next = count + 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            count  <= count_next;
        end
    end

    // Entry storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[mem_addr] <= push_data;
    end

endmodule

// File: rtl/branch_predictor_ras_bht.sv
// Fetch-stage predictor: predecodes the fetched MIPS word, predicts conditional
// branches from a PC-indexed 2-bit counter table and JR $31 from the RAS.
module branch_predictor_ras_bht
    import bp_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 256,
    parameter int unsigned RAS_DEPTH   = 8
) (
    input logic                       clk,
    input logic                       rst,
    branch_predictor_ras_bht_if.slave bp
);

    localparam int unsigned IDX = $clog2(BHT_ENTRIES);

    bht_ctr_t       bht [BHT_ENTRIES];
    logic [IDX-1:0] rd_idx, wr_idx;
    inst_class_t    cls;
    logic [4:0]     rs;
    logic [31:0]    pc4, br_target, j_target, link_addr, ras_top;
    logic           fire, rs_is_ra, ras_push, ras_pop, ras_is_empty, ras_is_full;
    logic           is_branch, taken, is_call, is_return;
    logic [31:0]    target;
    logic           unused_upd_pc;

    assign rd_idx        = bp.f_pc[IDX+1:2];
    assign wr_idx        = bp.upd_pc[IDX+1:2];
    assign unused_upd_pc = ^{bp.upd_pc[31:IDX+2], bp.upd_pc[1:0]};
    assign rs            = bp.f_inst[25:21];
    assign rs_is_ra      = (rs == REG_RA);
    assign pc4           = bp.f_pc + 32'd4;
    assign br_target     = pc4 + {{14{bp.f_inst[15]}}, bp.f_inst[15:0], 2'b00};
    assign j_target      = {pc4[31:28], bp.f_inst[25:0], 2'b00};
    assign link_addr     = bp.f_pc + 32'd8;
    assign cls           = classify(bp.f_inst);
    assign fire          = bp.f_valid & ~bp.stall;
    assign ras_push      = fire & is_call;
    assign ras_pop       = fire & (cls == CLS_INDIRECT) & rs_is_ra;

    // Predecode and target/direction prediction.
    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        target    = '0;
        is_call   = 1'b0;
        is_return = 1'b0;
        if (bp.f_valid) begin
            case (cls)
                CLS_JUMP: begin
                    is_branch = 1'b1;
                    taken     = 1'b1;
                    target    = j_target;
                    is_call   = (bp.f_inst[31:26] == OP_JAL);
                end
                CLS_COND: begin
                    is_branch = 1'b1;
                    taken     = bht[rd_idx][1];
                    target    = br_target;
                    is_call   = (bp.f_inst[31:26] == OP_REGIMM) &&
                                (bp.f_inst[20:16] == RT_BLTZAL || bp.f_inst[20:16] == RT_BGEZAL);
                end
                CLS_INDIRECT: begin
                    is_branch = 1'b1;
                    is_call   = (bp.f_inst[5:0] == FN_JALR);
                    is_return = (bp.f_inst[5:0] == FN_JR) && rs_is_ra;
                    if (is_return && !ras_is_empty) begin
                        taken  = 1'b1;
                        target = ras_top;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter table training from EX resolution; independent of fetch stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= BHT_INIT;
        end else if (bp.upd_valid && bp.upd_is_cond) begin
            bht[wr_idx] <= ctr_next(bht[wr_idx], bp.upd_taken);
        end
    end

    bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (bp.ras_flush),
        .push_data (link_addr),
        .top       (ras_top),
        .empty     (ras_is_empty),
        .full      (ras_is_full)
    );

    assign bp.pred_is_branch = is_branch;
    assign bp.pred_taken     = taken;
    assign bp.pred_target    = target;
    assign bp.pred_is_call   = is_call;
    assign bp.pred_is_return = is_return;
    assign bp.ras_empty      = ras_is_empty;
    assign bp.ras_full       = ras_is_full;

endmodule
